aes_word_loader: RTL and testbench
==================================

Name: aes_word_loader

Overview:
- Front-end/back-end adapter for the AES-128 encryption top.
- Accepts a 32-bit word stream over a valid/ready handshake and assembles it into four key words and four plaintext words, then issues a one-cycle start pulse to the core.
- Waits for the core's valid pulse, captures the four ciphertext words and streams them back out over a valid/ready handshake with a last marker.
- Sits between the bus/DMA word interface and the AES core.

Parameters:
- WAIT_MAX, 64, number of cycles after start without core valid before the transaction is aborted (>=2).
- CNT_W, 7, counter width for the wait timer; must hold WAIT_MAX.

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset, asynchronous, active-high
- s_valid  in  1  input word valid
- s_ready  out  1  loader can accept a word
- s_data  in  32  input word
- s_key_sel  in  1  frame type, sampled on the first word of a frame; only used when AES_KEY_REUSE_EN is defined
- key0_out..key3_out  out  32 each  key words to core
- plaintext0_out..plaintext3_out  out  32 each  plaintext words to core
- start_out  out  1  one-cycle start pulse to core
- aes_valid_in  in  1  core result valid pulse
- ciphertext0_in..ciphertext3_in  in  32 each  core result words
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts word
- m_data  out  32  ciphertext word
- m_last  out  1  high with the 4th ciphertext word
- busy_out  out  1  high in any state other than LOAD
- err_timeout  out  1  sticky; set on wait timeout, cleared only by RST

Behaviour:
- Reset (async): state=LOAD, word index=0, all key/plaintext/ciphertext registers=0, start_out=0, m_valid=0, m_last=0, err_timeout=0, timer=0.
- States: LOAD -> START -> WAIT -> DRAIN -> LOAD.
- LOAD:
  - s_ready=1.
  - Word accepted on s_valid&&s_ready.
  - Default frame is 8 words: words 0-3 go to key0..key3, words 4-7 go to plaintext0..plaintext3. Word 0 is the MSW, FIPS-197 w0 order.
  - Acceptance of word 7 moves to START and resets the index to 0.
- START:
  - start_out=1 for exactly one cycle (registered), s_ready=0.
  - Timer cleared; next state is WAIT.
- WAIT:
  - Timer increments each cycle.
  - aes_valid_in=1 captures ciphertext0..3_in into internal registers and moves to DRAIN.
  - If the timer reaches WAIT_MAX-1 with no valid: set err_timeout, move to LOAD, discard the result.
  - If aes_valid_in arrives on the same cycle as the timeout, the valid wins.
- DRAIN:
  - m_valid=1, m_data=ct[idx], m_last=(idx==3).
  - idx advances on m_valid&&m_ready. m_data must be held stable while m_ready=0.
  - Acceptance of idx 3 moves to LOAD with m_valid deasserted the next cycle.
- Key and plaintext outputs are held stable from START through the end of DRAIN and change only on LOAD acceptances.
- aes_valid_in outside WAIT is ignored.
- s_valid outside LOAD is ignored (s_ready=0), and no word is lost or duplicated.
- Throughput: 8 load cycles + 1 start + core latency + 4 drain cycles minimum. No overlap between frames.
- RST mid-operation aborts everything immediately; a partial frame is discarded.

Optional Feature:
- AES_KEY_REUSE_EN defined:
  - s_key_sel is sampled on the first word of a frame.
  - s_key_sel=1: 4-word key frame loads key0..3, sets an internal key_loaded flag, returns to LOAD, no start.
  - s_key_sel=0: 4-word plaintext frame loads plaintext0..3, then goes to START using the stored key.
  - A plaintext frame completed with key_loaded=0 goes to START with the reset-value key (all zero). key_loaded is cleared by RST only.
- Not defined:
  - s_key_sel is ignored; every frame is 8 words (key then plaintext).

Test Plan:
- FIPS-197 App. B, using the AES_TOP core or a model: stream key 2b7e1516 28aed2a6 abf71588 09cf4f3c then pt 3243f6a8 885a308d 313198a2 e0370734 -> exactly one start_out pulse, then m_data 3925841d 02dc09fb dc118597 196a0b32 with m_last on the 4th word.
- Backpressure: hold m_ready=0 for 5 cycles per word, and drop s_valid randomly while loading -> same ciphertext, m_data stable while stalled, no duplicated or dropped words, s_ready=0 from START until DRAIN ends.
- Timeout: core model never asserts valid, WAIT_MAX=8 -> err_timeout=1 eight cycles after start, state returns to LOAD, m_valid never asserted; a following frame completes normally with err_timeout still 1.
- Reset mid-frame: assert RST after 3 loaded words, then load a full frame -> outputs are zero during reset, and start fires only after 8 new words.
- Spurious aes_valid_in during LOAD and DRAIN -> ignored; captured ciphertext unchanged.
- AES_KEY_REUSE_EN: one key frame (sel=1), then two plaintext frames (sel=0) -> two start pulses, each with key words unchanged and the correct ciphertext per frame.

Source files
------------

// File: rtl/aes_word_loader.sv
// Word-stream adapter around the AES-128 core: loads key/plaintext words, pulses start,
// waits for the result and drains the ciphertext. Optional macro: AES_KEY_REUSE_EN.
module aes_word_loader #(
  parameter int WAIT_MAX = 64,
  parameter int CNT_W    = 7
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_key_sel,
  output logic [31:0] key0_out,
  output logic [31:0] key1_out,
  output logic [31:0] key2_out,
  output logic [31:0] key3_out,
  output logic [31:0] plaintext0_out,
  output logic [31:0] plaintext1_out,
  output logic [31:0] plaintext2_out,
  output logic [31:0] plaintext3_out,
  output logic        start_out,
  input  logic        aes_valid_in,
  input  logic [31:0] ciphertext0_in,
  input  logic [31:0] ciphertext1_in,
  input  logic [31:0] ciphertext2_in,
  input  logic [31:0] ciphertext3_in,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        busy_out,
  output logic        err_timeout
);

  typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_t;

  state_t           r_state, w_next;
  logic [2:0]       r_idx;
  logic [31:0]      r_key [4];
  logic [31:0]      r_pt  [4];
  logic [31:0]      r_ct  [4];
  logic [CNT_W-1:0] r_timer;
  logic             r_start;
  logic             r_err;

  logic       w_s_fire, w_m_fire, w_last_word, w_go, w_to_key, w_timer_max;
  logic [1:0] w_slot;

  assign w_s_fire    = s_valid && (r_state == LOAD);
  assign w_m_fire    = m_ready && (r_state == DRAIN);
  assign w_slot      = r_idx[1:0];
  assign w_timer_max = (r_timer == CNT_W'(WAIT_MAX - 1));

`ifdef AES_KEY_REUSE_EN
  logic r_key_sel, r_key_loaded, w_frame_key;

  // Frame type comes straight from the port on word 0, from the latched copy afterwards.
  assign w_frame_key = (r_idx == 3'd0) ? s_key_sel : r_key_sel;
  assign w_last_word = (r_idx == 3'd3);
  assign w_to_key    = w_frame_key;
  assign w_go        = w_s_fire && w_last_word && !w_frame_key;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_key_sel    <= 1'b0;
      r_key_loaded <= 1'b0;
    end else if (w_s_fire) begin
      if (r_idx == 3'd0) r_key_sel <= s_key_sel;
      if (w_last_word && w_frame_key) r_key_loaded <= 1'b1;
    end
  end

  assign key0_out = r_key_loaded ? r_key[0] : '0;
  assign key1_out = r_key_loaded ? r_key[1] : '0;
  assign key2_out = r_key_loaded ? r_key[2] : '0;
  assign key3_out = r_key_loaded ? r_key[3] : '0;
`else
  logic w_unused_key_sel;

  assign w_unused_key_sel = s_key_sel;
  assign w_last_word      = (r_idx == 3'd7);
  assign w_to_key         = !r_idx[2];
  assign w_go             = w_s_fire && w_last_word;

  assign key0_out = r_key[0];
  assign key1_out = r_key[1];
  assign key2_out = r_key[2];
  assign key3_out = r_key[3];
`endif

  always_comb begin
    // NOTE: default assigned first so every path drives w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      LOAD:    if (w_go) w_next = START;
      START:   w_next = WAIT;
      WAIT:    if (aes_valid_in) w_next = DRAIN;
               else if (w_timer_max) w_next = LOAD;
      DRAIN:   if (w_m_fire && (r_idx == 3'd3)) w_next = LOAD;
      default: w_next = LOAD;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= LOAD;
      r_idx   <= '0;
      r_timer <= '0;
      r_start <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_next;
      r_start <= w_go;
      if (w_s_fire)      r_idx <= w_last_word ? 3'd0 : r_idx + 3'd1;
      else if (w_m_fire) r_idx <= (r_idx == 3'd3) ? 3'd0 : r_idx + 3'd1;
      // Timer counts cycles since the start pulse, so it reads 1 on the first WAIT cycle.
      if (w_go) r_timer <= '0;
      else if (r_state == START || r_state == WAIT) r_timer <= r_timer + 1'b1;
      if (r_state == WAIT && !aes_valid_in && w_timer_max) r_err <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: these arrays are reset because the core-facing outputs must read zero in reset.
      for (int i = 0; i < 4; i++) begin
        r_key[i] <= '0;
        r_pt[i]  <= '0;
        r_ct[i]  <= '0;
      end
    end else begin
      if (w_s_fire) begin
        if (w_to_key) r_key[w_slot] <= s_data;
        else          r_pt[w_slot]  <= s_data;
      end
      if (r_state == WAIT && aes_valid_in) begin
        r_ct[0] <= ciphertext0_in;
        r_ct[1] <= ciphertext1_in;
        r_ct[2] <= ciphertext2_in;
        r_ct[3] <= ciphertext3_in;
      end
    end
  end

  assign s_ready        = (r_state == LOAD);
  assign busy_out       = (r_state != LOAD);
  assign start_out      = r_start;
  assign m_valid        = (r_state == DRAIN);
  assign m_data         = r_ct[w_slot];
  assign m_last         = (r_state == DRAIN) && (r_idx == 3'd3);
  assign err_timeout    = r_err;
  assign plaintext0_out = r_pt[0];
  assign plaintext1_out = r_pt[1];
  assign plaintext2_out = r_pt[2];
  assign plaintext3_out = r_pt[3];

endmodule

// File: tb/tb_aes_word_loader.sv
// Self-checking bench for aes_word_loader with a behavioural core model (WAIT_MAX=8).
module tb_aes_word_loader;

  localparam int LAT = 3;

  logic        CLK, RST;
  logic        s_valid, s_ready, s_key_sel;
  logic [31:0] s_data;
  logic [31:0] key0_out, key1_out, key2_out, key3_out;
  logic [31:0] plaintext0_out, plaintext1_out, plaintext2_out, plaintext3_out;
  logic        start_out, aes_valid_in;
  logic [31:0] ciphertext0_in, ciphertext1_in, ciphertext2_in, ciphertext3_in;
  logic        m_valid, m_ready, m_last, busy_out, err_timeout;
  logic [31:0] m_data;

  aes_word_loader #(.WAIT_MAX(8), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_key_sel(s_key_sel),
    .key0_out(key0_out), .key1_out(key1_out), .key2_out(key2_out), .key3_out(key3_out),
    .plaintext0_out(plaintext0_out), .plaintext1_out(plaintext1_out),
    .plaintext2_out(plaintext2_out), .plaintext3_out(plaintext3_out),
    .start_out(start_out), .aes_valid_in(aes_valid_in),
    .ciphertext0_in(ciphertext0_in), .ciphertext1_in(ciphertext1_in),
    .ciphertext2_in(ciphertext2_in), .ciphertext3_in(ciphertext3_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy_out(busy_out), .err_timeout(err_timeout)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [31:0] key [4];
    logic [31:0] pt  [4];
    logic [31:0] ct  [4];
    bit          stall;
    bit          gaps;
  } vec_t;

  vec_t        vecs [4];
  logic [31:0] spur_words [4];
  logic [31:0] key_o [4];
  logic [31:0] pt_o  [4];
  logic [31:0] core_ct [4];
  logic        core_valid, spur_valid, core_en;
  int          core_cnt;

  int checks = 0, errors = 0;
  int stall_viol = 0, ready_viol = 0, start_seen = 0, mv_cycles = 0, exp_starts = 0;

  assign key_o[0] = key0_out;       assign key_o[1] = key1_out;
  assign key_o[2] = key2_out;       assign key_o[3] = key3_out;
  assign pt_o[0]  = plaintext0_out; assign pt_o[1]  = plaintext1_out;
  assign pt_o[2]  = plaintext2_out; assign pt_o[3]  = plaintext3_out;

  assign aes_valid_in   = core_valid | spur_valid;
  assign ciphertext0_in = spur_valid ? spur_words[0] : core_ct[0];
  assign ciphertext1_in = spur_valid ? spur_words[1] : core_ct[1];
  assign ciphertext2_in = spur_valid ? spur_words[2] : core_ct[2];
  assign ciphertext3_in = spur_valid ? spur_words[3] : core_ct[3];

  // Core model: FIPS-197 App. B vector is answered with its real ciphertext,
  // anything else with ~(pt ^ key) word by word, LAT cycles after start.
  initial begin
    core_cnt   = 0;
    core_valid = 1'b0;
    for (int i = 0; i < 4; i++) core_ct[i] = '0;
    forever begin
      @(negedge CLK);
      core_valid = 1'b0;
      if (core_cnt != 0) begin
        core_cnt--;
        if (core_cnt == 0) core_valid = 1'b1;
      end else if (start_out && core_en) begin
        if (key_o[0] == 32'h2b7e1516 && pt_o[0] == 32'h3243f6a8) begin
          core_ct[0] = 32'h3925841d; core_ct[1] = 32'h02dc09fb;
          core_ct[2] = 32'hdc118597; core_ct[3] = 32'h196a0b32;
        end else begin
          for (int i = 0; i < 4; i++) core_ct[i] = ~(pt_o[i] ^ key_o[i]);
        end
        core_cnt = LAT;
      end
    end
  end

  // Protocol monitor, sampled mid-cycle after the drivers have settled.
  initial begin
    logic        p_v, p_r, p_l;
    logic [31:0] p_d;
    p_v = 1'b0; p_r = 1'b0; p_l = 1'b0; p_d = '0;
    forever begin
      @(negedge CLK);
      #1;
      if (p_v && !p_r && (m_valid !== 1'b1 || m_data !== p_d || m_last !== p_l)) stall_viol++;
      if (busy_out && s_ready) ready_viol++;
      if (start_out) start_seen++;
      if (m_valid) mv_cycles++;
      p_v = m_valid; p_r = m_ready; p_d = m_data; p_l = m_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] frame_word(input int r, input int i);
    return (i < 4) ? vecs[r].key[i] : vecs[r].pt[i-4];
  endfunction

  // Called just after a negedge; returns at the negedge following acceptance.
  task automatic send_word(input logic [31:0] d, input logic sel);
    int n;
    s_data = d; s_key_sel = sel; s_valid = 1'b1; n = 0;
    while (!s_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("s_ready_wait", s_ready, 1);
    @(negedge CLK);
    s_valid = 1'b0;
  endtask

  // Words lo..hi of row r; key words carry s_key_sel=1, plaintext words 0.
  task automatic send_range(input int r, input int lo, input int hi, input bit gaps);
    for (int i = lo; i <= hi; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge CLK);
      send_word(frame_word(r, i), i < 4);
    end
  endtask

  task automatic check_started(input int r);
    check($sformatf("start_r%0d", r), start_out, 1);
    check($sformatf("s_ready_start_r%0d", r), s_ready, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("key%0d_r%0d", i, r), key_o[i], vecs[r].key[i]);
      check($sformatf("pt%0d_r%0d", i, r), pt_o[i], vecs[r].pt[i]);
    end
    exp_starts++;
  endtask

  task automatic recv(input logic [31:0] e [4], input bit stall, input string tag);
    int n;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!m_valid && n < 100) begin
        @(negedge CLK);
        n++;
      end
      check($sformatf("m_valid_wait_%s", tag), m_valid, 1);
      if (stall) repeat (5) @(negedge CLK);
      check($sformatf("m_data%0d_%s", i, tag), m_data, e[i]);
      check($sformatf("m_last%0d_%s", i, tag), m_last, (i == 3));
      m_ready = 1'b1;
      @(negedge CLK);
      m_ready = 1'b0;
    end
    check($sformatf("m_valid_after_%s", tag), m_valid, 0);
    check($sformatf("busy_after_%s", tag), busy_out, 0);
  endtask

  initial begin
    int s0, mv0, n;

    vecs[0].key = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
    vecs[0].pt  = '{32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734};
    vecs[0].ct  = '{32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32};
    vecs[0].stall = 1'b0; vecs[0].gaps = 1'b0;
    vecs[1].key = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333};
    vecs[1].pt  = '{32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210};
    vecs[1].ct  = '{32'hfedcba98, 32'h67452301, 32'h23016745, 32'hba98fedc};
    vecs[1].stall = 1'b1; vecs[1].gaps = 1'b1;
    vecs[2].key = '{32'hffff0000, 32'h0f0f0f0f, 32'h12345678, 32'h87654321};
    vecs[2].pt  = '{32'ha5a5a5a5, 32'h5a5a5a5a, 32'h00000000, 32'hffffffff};
    vecs[2].ct  = '{32'ha5a55a5a, 32'haaaaaaaa, 32'hedcba987, 32'h87654321};
    vecs[2].stall = 1'b0; vecs[2].gaps = 1'b1;
    vecs[3].key = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333};
    vecs[3].pt  = '{32'hfedcba98, 32'h76543210, 32'h01234567, 32'h89abcdef};
    vecs[3].ct  = '{32'h01234567, 32'h98badcfe, 32'hdcfe98ba, 32'h45670123};
    vecs[3].stall = 1'b1; vecs[3].gaps = 1'b0;
    spur_words = '{32'hc0de0000, 32'hc0de0001, 32'hc0de0002, 32'hc0de0003};

    RST = 1'b1; s_valid = 1'b0; s_data = '0; s_key_sel = 1'b0;
    m_ready = 1'b0; spur_valid = 1'b0; core_en = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_key0", key0_out, 0);
    check("rst_pt3", plaintext3_out, 0);
    check("rst_start", start_out, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy_out, 0);
    check("rst_err", err_timeout, 0);
    check("rst_s_ready", s_ready, 1);
    RST = 1'b0;
    @(negedge CLK);

    for (int r = 0; r < 4; r++) begin
      send_range(r, 0, 7, vecs[r].gaps);
      check_started(r);
      recv(vecs[r].ct, vecs[r].stall, $sformatf("row%0d", r));
    end

    // Spurious core valid while idle and while draining must be ignored.
    spur_valid = 1'b1;
    @(negedge CLK);
    spur_valid = 1'b0;
    check("spur_load_busy", busy_out, 0);
    check("spur_load_m_valid", m_valid, 0);
    send_range(0, 0, 7, 1'b0);
    check_started(0);
    n = 0;
    while (!m_valid && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("spur_drain_wait", m_valid, 1);
    spur_valid = 1'b1;
    @(negedge CLK);
    spur_valid = 1'b0;
    recv(vecs[0].ct, 1'b0, "spur_drain");

    // Core valid on the last allowed WAIT cycle beats the timeout.
    core_en = 1'b0;
    send_range(2, 0, 7, 1'b0);
    check_started(2);
    repeat (7) @(negedge CLK);
    check("edge_busy", busy_out, 1);
    spur_valid = 1'b1;
    @(negedge CLK);
    spur_valid = 1'b0;
    check("edge_valid_wins", m_valid, 1);
    check("edge_no_err", err_timeout, 0);
    recv(spur_words, 1'b0, "edge");

    // No core response: sticky timeout eight cycles after start.
    mv0 = mv_cycles;
    send_range(1, 0, 7, 1'b0);
    check_started(1);
    repeat (7) @(negedge CLK);
    check("to_err_early", err_timeout, 0);
    check("to_busy_early", busy_out, 1);
    @(negedge CLK);
    check("to_err_set", err_timeout, 1);
    check("to_busy_clear", busy_out, 0);
    check("to_s_ready", s_ready, 1);
    check("to_m_valid", m_valid, 0);
    check("to_no_m_valid", mv_cycles, mv0);
    core_en = 1'b1;
    send_range(2, 0, 7, 1'b0);
    check_started(2);
    recv(vecs[2].ct, 1'b0, "after_to");
    check("to_err_sticky", err_timeout, 1);

    // Reset after three words discards the partial frame.
    send_range(0, 0, 2, 1'b0);
    RST = 1'b1;
    #1;
    check("mid_rst_key0", key0_out, 0);
    check("mid_rst_key2", key2_out, 0);
    check("mid_rst_err", err_timeout, 0);
    check("mid_rst_start", start_out, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    s0 = start_seen;
    send_range(0, 0, 6, 1'b0);
    check("mid_rst_no_start", start_seen, s0);
    check("mid_rst_not_busy", busy_out, 0);
    send_range(0, 7, 7, 1'b0);
    check_started(0);
    recv(vecs[0].ct, 1'b0, "mid_rst");

`ifdef AES_KEY_REUSE_EN
    // One key frame, then two plaintext frames using the stored key.
    s0 = start_seen;
    send_range(1, 0, 3, 1'b0);
    check("reuse_key_no_start", start_seen, s0);
    check("reuse_key_idle", busy_out, 0);
    send_range(1, 4, 7, 1'b0);
    check_started(1);
    recv(vecs[1].ct, 1'b0, "reuse_a");
    send_range(3, 4, 7, 1'b0);
    check_started(3);
    recv(vecs[3].ct, 1'b0, "reuse_b");
`endif

    repeat (2) @(negedge CLK);
    check("m_data_stable_in_stall", stall_viol, 0);
    check("s_ready_low_while_busy", ready_viol, 0);
    check("start_pulse_count", start_seen, exp_starts);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
